// File: rtl/fifo_ext_if.sv
// fifo_ext_if: handshake/data bundle for fifo_ext.
//   master: producer/consumer side (drives wr_en, rd_en, din)
//   slave : FIFO side (drives dout, status flags, count, error pulses)
//   count is log2(data_length)+1 bits wide so it can hold 0..data_length.
interface fifo_ext_if #(
    parameter int data_width  = 8,
    parameter int data_length = 16
);
    localparam int CW = $clog2(data_length) + 1;

    logic                  wr_en;
    logic                  rd_en;
    logic [data_width-1:0] din;
    logic [data_width-1:0] dout;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, rd_en, din,
        input  dout, empty, full, almost_empty, almost_full, count, overflow, underflow
    );

    modport slave (
        input  wr_en, rd_en, din,
        output dout, empty, full, almost_empty, almost_full, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ext.sv
// fifo_ext: single-clock circular-buffer FIFO with status flags and
// overflow/underflow pulses.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (wins over wr_en/rd_en)
//   bus  : fifo_ext_if.slave
//          wr_en/din   - write request and data
//          rd_en       - pop request
//          dout        - registered read data (fwft=0) or head word (fwft=1)
//          empty/full/almost_empty/almost_full - decoded from count
//          count       - words stored, 0..data_length
//          overflow    - one-cycle pulse after a rejected write
//          underflow   - one-cycle pulse after a rejected read
module fifo_ext #(
    parameter int data_width    = 8,
    parameter int data_length   = 16,
    parameter int afull_thresh  = 14,
    parameter int aempty_thresh = 2,
    parameter bit fwft          = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    fifo_ext_if.slave  bus
);
    localparam int AW = $clog2(data_length);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(data_length);
    localparam logic [CW-1:0] AFULL_CNT = CW'(afull_thresh);
    localparam logic [CW-1:0] AEMPTY_CNT = CW'(aempty_thresh);

    logic [data_width-1:0] mem [data_length];
    logic [AW-1:0]         wptr, rptr;
    logic [CW-1:0]         cnt;
    logic                  ovf, udf;
    logic                  is_empty, is_full;
    logic                  rd_ok, wr_ok;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == FULL_CNT);

    // A write into a full FIFO is only legal when a pop frees the slot in
    // the same cycle; a pop from empty is never legal (no read-through).
    assign rd_ok = bus.rd_en && !is_empty;
    assign wr_ok = bus.wr_en && (!is_full || rd_ok);

    // Storage is not cleared on reset: reset zeroes count, so stale words
    // are unreachable until overwritten.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok)
            mem[wptr] <= bus.din;
    end

    // Pointers wrap naturally since data_length is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            udf  <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            if (wr_ok && !rd_ok)      cnt <= cnt + 1'b1;
            else if (rd_ok && !wr_ok) cnt <= cnt - 1'b1;
            ovf <= bus.wr_en && !wr_ok;
            udf <= bus.rd_en && is_empty;
        end
    end

    generate
        if (fwft) begin : g_fwft
            // Head word shown directly; undefined content while empty.
            assign bus.dout = mem[rptr];
        end else begin : g_reg
            logic [data_width-1:0] dout_r;
            always_ff @(posedge clk) begin
                if (rst)        dout_r <= '0;
                else if (rd_ok) dout_r <= mem[rptr];
            end
            assign bus.dout = dout_r;
        end
    endgenerate

    assign bus.count        = cnt;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_empty = (cnt <= AEMPTY_CNT);
    assign bus.almost_full  = (cnt >= AFULL_CNT);
    assign bus.overflow     = ovf;
    assign bus.underflow    = udf;
endmodule

// File: tb/tb_fifo_ext.sv
module tb_fifo_ext;
    logic       clk = 1'b0;
    logic       rst, wr, rd;
    logic [7:0] din;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    fifo_ext_if #(.data_width(8), .data_length(16)) if0 ();
    fifo_ext_if #(.data_width(8), .data_length(16)) if1 ();

    assign if0.wr_en = wr;
    assign if0.rd_en = rd;
    assign if0.din   = din;
    assign if1.wr_en = wr;
    assign if1.rd_en = rd;
    assign if1.din   = din;

    fifo_ext #(.data_width(8), .data_length(16), .afull_thresh(14),
               .aempty_thresh(2), .fwft(1'b0)) u_reg (.clk(clk), .rst(rst), .bus(if0.slave));
    fifo_ext #(.data_width(8), .data_length(16), .afull_thresh(14),
               .aempty_thresh(2), .fwft(1'b1)) u_fwft (.clk(clk), .rst(rst), .bus(if1.slave));

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        int         cnt;
        logic       ovf;
        logic       udf;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] q[$];

    function automatic void add(logic w, logic r, logic [7:0] d, int c,
                                logic o, logic u, logic [7:0] dq);
        vec_t v;
        v.wr = w; v.rd = r; v.din = d; v.cnt = c; v.ovf = o; v.udf = u; v.dout = dq;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled there too.
    task automatic cyc(input logic r_, input logic w_, input logic rd_, input logic [7:0] d_);
        rst = r_; wr = w_; rd = rd_; din = d_;
        @(posedge clk);
        #1;
        rst = 1'b0; wr = 1'b0; rd = 1'b0;
    endtask

    // Flags decoded from the expected word count.
    task automatic chk_state(input string nm, input int c);
        chk({nm, ".count"}, int'(if0.count), c);
        chk({nm, ".empty"}, int'(if0.empty), int'(c == 0));
        chk({nm, ".full"},  int'(if0.full),  int'(c == 16));
        chk({nm, ".aempty"}, int'(if0.almost_empty), int'(c <= 2));
        chk({nm, ".afull"},  int'(if0.almost_full),  int'(c >= 14));
        chk({nm, ".count_fwft"}, int'(if1.count), c);
    endtask

    initial begin
        rst = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
        #1;

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk_state("reset", 0);
        chk("reset.ovf",  int'(if0.overflow), 0);
        chk("reset.udf",  int'(if0.underflow), 0);
        chk("reset.dout", int'(if0.dout), 0);

        // Fill, overflow, full simultaneous, drain, underflow, empty simultaneous
        for (int i = 0; i < 16; i++) add(1, 0, 8'(i), i + 1, 0, 0, 8'h00);
        add(1, 0, 8'h77, 16, 1, 0, 8'h00);     // 17th write dropped
        add(0, 0, 8'h00, 16, 0, 0, 8'h00);     // overflow lasts one cycle
        add(1, 1, 8'h10, 16, 0, 0, 8'h00);     // full: both accepted
        for (int i = 1; i < 16; i++) add(0, 1, 8'h00, 16 - i, 0, 0, 8'(i));
        add(0, 1, 8'h00, 0, 0, 0, 8'h10);      // last word is the one written at full
        add(0, 1, 8'h00, 0, 0, 1, 8'h10);      // underflow, dout holds
        add(0, 0, 8'h00, 0, 0, 0, 8'h10);
        add(1, 1, 8'h42, 1, 0, 1, 8'h10);      // empty: only write accepted
        add(0, 1, 8'h00, 0, 0, 0, 8'h42);

        for (int k = 0; k < tbl.size(); k++) begin
            string nm;
            nm = $sformatf("vec%0d", k);
            cyc(1'b0, tbl[k].wr, tbl[k].rd, tbl[k].din);
            chk_state(nm, tbl[k].cnt);
            chk({nm, ".ovf"},  int'(if0.overflow),  int'(tbl[k].ovf));
            chk({nm, ".udf"},  int'(if0.underflow), int'(tbl[k].udf));
            chk({nm, ".dout"}, int'(if0.dout),      int'(tbl[k].dout));
        end

        // Wrap-around: interleaved traffic with count kept in 8..12
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
            q.push_back(8'(8'hC0 + i));
        end
        chk_state("wrap.fill", 10);
        for (int i = 0; i < 40; i++) begin
            logic w, r;
            logic [7:0] d, e;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (q.size() >= 12 && w && !r) w = 1'b0;
            if (q.size() <= 8 && r && !w) r = 1'b0;
            d = 8'($urandom);
            e = 8'h00;
            cyc(1'b0, w, r, d);
            if (r) e = q.pop_front();
            if (w) q.push_back(d);
            chk($sformatf("wrap%0d.count", i), int'(if0.count), q.size());
            if (r) chk($sformatf("wrap%0d.dout", i), int'(if0.dout), int'(e));
        end

        // First-word-fall-through
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("fwft.reset_empty", int'(if1.empty), 1);
        cyc(1'b0, 1'b1, 1'b0, 8'hA5);
        chk("fwft.empty_after_wr", int'(if1.empty), 0);
        chk("fwft.dout_a5", int'(if1.dout), 8'hA5);
        cyc(1'b0, 1'b1, 1'b0, 8'h5A);
        chk("fwft.dout_hold", int'(if1.dout), 8'hA5);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("fwft.dout_next", int'(if1.dout), 8'h5A);
        chk("fwft.count1", int'(if1.count), 1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("fwft.empty_end", int'(if1.empty), 1);

        // Reset mid-operation with a concurrent write
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 1'b0, 8'(8'h90 + i));
        chk_state("midrst.pre", 9);
        cyc(1'b1, 1'b1, 1'b0, 8'hEE);
        chk_state("midrst.post", 0);
        chk("midrst.dout", int'(if0.dout), 0);
        cyc(1'b0, 1'b1, 1'b0, 8'h3C);
        chk_state("midrst.wr", 1);
        chk("midrst.fwft_dout", int'(if1.dout), 8'h3C);
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        chk("midrst.dout_rd", int'(if0.dout), 8'h3C);
        chk_state("midrst.rd", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_ext.md
FIFO_EXT -- requirements
Module: fifo_ext

Interface
REQ-001 SHALL have parameter data_width, default 8, width of din/dout in bits.
REQ-002 SHALL have parameter data_length, default 16, storage depth in words; power of two, >= 4.
REQ-003 SHALL have parameter afull_thresh, default 14, count at or above which almost_full asserts; 1..data_length.
REQ-004 SHALL have parameter aempty_thresh, default 2, count at or below which almost_empty asserts; 0..data_length-1.
REQ-005 SHALL have parameter fwft, default 0, output mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port rd_en  input  1  read (pop) request.
REQ-010 SHALL have port din  input  data_width  write data.
REQ-011 SHALL have port dout  output  data_width  read data.
REQ-012 SHALL have port empty  output  1  count == 0.
REQ-013 SHALL have port full  output  1  count == data_length.
REQ-014 SHALL have port almost_empty  output  1  count <= aempty_thresh.
REQ-015 SHALL have port almost_full  output  1  count >= afull_thresh.
REQ-016 SHALL have port count  output  log2(data_length)+1  words stored, 0..data_length.
REQ-017 SHALL have port overflow  output  1  one-cycle pulse: write rejected.
REQ-018 SHALL have port underflow  output  1  one-cycle pulse: read rejected.

Function
REQ-019 SHALL store words in a circular buffer with write and read pointers of log2(data_length) bits, wrapping data_length-1 -> 0 with no gap.
REQ-020 SHALL accept a write when wr_en=1 and (full=0, or rd_en=1 is accepted in the same cycle); din is stored at the write pointer, pointer advances.
REQ-021 SHALL accept a read when rd_en=1 and empty=0; read pointer advances.
REQ-022 SHALL, on empty with wr_en=rd_en=1, accept only the write and pulse underflow; read-through is not supported.
REQ-023 SHALL, on full with wr_en=rd_en=1, accept both; count stays data_length, full stays 1, overflow stays 0.
REQ-024 SHALL, on wr_en=1 to full without accepted read, drop din, leave state unchanged, drive overflow=1 for the next cycle only.
REQ-025 SHALL, on rd_en=1 when empty, leave state and dout unchanged, drive underflow=1 for the next cycle only.
REQ-026 SHALL update count registered: +1 write only, -1 read only, unchanged for both or neither; visible the cycle after the edge.
REQ-027 SHALL derive empty, full, almost_empty, almost_full combinationally from count only, so flags change in the same cycle as count.
REQ-028 SHALL, with fwft=0, register dout: word at read pointer appears the cycle after the accepted read; dout holds its value otherwise.
REQ-029 SHALL, with fwft=1, drive dout = word at read pointer whenever empty=0; rd_en pops it, next word appears the cycle after the edge; dout is don't-care while empty=1.
REQ-030 SHALL preserve strict FIFO order across any number of pointer wrap-arounds.

Reset
REQ-031 SHALL, when rst=1 at a rising clk edge, zero both pointers and count, and zero overflow, underflow and (fwft=0) dout.
REQ-032 SHALL show after reset: empty=1, almost_empty=1, full=0, almost_full=0, count=0.
REQ-033 SHALL give rst priority over wr_en/rd_en in the same cycle; mid-operation reset discards all stored words.
REQ-034 SHALL not require storage array clearing on reset; no stale word is ever output after reset.

Verification
REQ-035 SHALL cover fill/drain (fwft=0): write 0..15 -> full=1, count=16, almost_full from count 14; read 16 -> dout 0..15 in order, each one cycle after read, empty=1.
REQ-036 SHALL cover overflow/underflow: 17th write with full=1 -> overflow pulse 1 cycle, count stays 16; read at empty -> underflow pulse, dout unchanged.
REQ-037 SHALL cover simultaneous access: full + wr/rd together -> count 16, no overflow; empty + wr/rd together -> count 1, underflow pulse.
REQ-038 SHALL cover wrap-around: 40 interleaved write/read cycles at count 8..12 -> all data returned in order, count correct each cycle.
REQ-039 SHALL cover fwft=1: write 0xA5 to empty -> next cycle empty=0, dout=0xA5 with no rd_en; pop -> next word or empty=1.
REQ-040 SHALL cover reset mid-operation: count=9, assert rst one cycle with wr_en=1 -> count=0, empty=1, write ignored, next write reads back correctly.
